// File: rtl/stream_mux_rr_if.sv
// ============================================================================
// stream_mux_rr_if : handshake/data bundle between N producers, the mux and
//                    one consumer.
// Revision 1.0
// ============================================================================
`default_nettype none

interface stream_mux_rr_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
);
  localparam int SELW = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [SELW-1:0]           sel;
  logic [WIDTH-1:0]          out_data;
  logic [SELW-1:0]           out_chan;
  logic                      out_valid;
  logic                      out_ready;

  // Environment side: producers, select source and consumer.
  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  // Multiplexer side.
  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/stream_mux_rr.sv
// ============================================================================
// stream_mux_rr : N-channel registered stream mux, external select (MODE 0)
//                 or round-robin arbitration (MODE 1).
// Revision 1.0
// ============================================================================
`default_nettype none

module stream_mux_rr #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0
) (
  input  logic            clk,
  input  logic            rst,
  stream_mux_rr_if.slave  bus
);
  localparam int SELW = $clog2(CHANNELS);

  logic                load_en;
  logic                grant_vld;
  logic [SELW-1:0]     grant_idx;
  logic                xfer;
  logic [WIDTH-1:0]    grant_data;
  logic [CHANNELS-1:0] in_ready_w;

  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0]     out_chan_q, out_chan_d;
  logic                out_valid_q, out_valid_d;

  assign load_en = !out_valid_q || bus.out_ready;
  assign xfer    = !rst && load_en && grant_vld;

  generate
    if (MODE == 0) begin : g_ext_sel
      // Out-of-range select values grant nothing.
      always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (({1'b0, bus.sel} < (SELW+1)'(CHANNELS)) && bus.in_valid[bus.sel]) begin
          grant_vld = 1'b1;
          grant_idx = bus.sel;
        end
      end
    end else begin : g_round_robin
      logic [SELW-1:0] ptr_q, ptr_d;

      // Scan from the highest offset down so the closest channel to ptr wins.
      always_comb begin
        logic [SELW:0]   sum;
        logic [SELW-1:0] idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        sum       = '0;
        idx       = '0;
        for (int k = CHANNELS-1; k >= 0; k--) begin
          sum = {1'b0, ptr_q} + (SELW+1)'(k);
          if (sum >= (SELW+1)'(CHANNELS)) begin
            sum = sum - (SELW+1)'(CHANNELS);
          end
          idx = sum[SELW-1:0];
          if (bus.in_valid[idx]) begin
            grant_vld = 1'b1;
            grant_idx = idx;
          end
        end
      end

      always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
          ptr_d = (grant_idx == SELW'(CHANNELS-1)) ? '0 : grant_idx + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          ptr_q <= '0;
        end else begin
          ptr_q <= ptr_d;
        end
      end
    end
  endgenerate

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_idx == SELW'(i)) begin
        grant_data = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    in_ready_w = '0;
    if (xfer) begin
      in_ready_w[grant_idx] = 1'b1;
    end
  end

  assign bus.in_ready = in_ready_w;

  // Without a grant the data/channel fields keep their last beat.
  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    if (load_en) begin
      out_valid_d = grant_vld;
      if (grant_vld) begin
        out_data_d = grant_data;
        out_chan_d = grant_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_valid = out_valid_q;

  a_ready_onehot : assert property (@(posedge clk) $onehot0(bus.in_ready));
  a_stall_frozen : assert property (@(posedge clk) disable iff (rst)
    (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(out_data_q) && $stable(out_chan_q)));

endmodule

`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
// ============================================================================
// tb_stream_mux_rr : directed + random bench for both mux modes against a
//                    behavioural model.
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_stream_mux_rr;
  localparam int W  = 32;
  localparam int C  = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_mux_rr_if #(.WIDTH(W), .CHANNELS(C)) if0 ();
  stream_mux_rr_if #(.WIDTH(W), .CHANNELS(C)) if1 ();

  stream_mux_rr #(.WIDTH(W), .CHANNELS(C), .MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  stream_mux_rr #(.WIDTH(W), .CHANNELS(C), .MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  logic [C-1:0]   iv   [2];
  logic [C*W-1:0] id   [2];
  logic [SW-1:0]  sel  [2];
  logic           ordy [2];

  assign if0.in_valid  = iv[0];
  assign if0.in_data   = id[0];
  assign if0.sel       = sel[0];
  assign if0.out_ready = ordy[0];
  assign if1.in_valid  = iv[1];
  assign if1.in_data   = id[1];
  assign if1.sel       = sel[1];
  assign if1.out_ready = ordy[1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: output register contents and arbitration pointer.
  logic          m_valid [2];
  logic [W-1:0]  m_data  [2];
  logic [SW-1:0] m_chan  [2];
  int            m_ptr   [2];
  bit            armed   [2];

  task automatic model_step(input int d, input logic [C-1:0] v, input logic [C*W-1:0] data,
                            input logic [SW-1:0] s, input logic ordy_i,
                            input logic [C-1:0] rdy, input logic ov,
                            input logic [W-1:0] od, input logic [SW-1:0] oc);
    int           g;
    int           c;
    bit           load;
    logic [C-1:0] er;
    string        p;
    p = (d == 0) ? "sel" : "rr";
    if (armed[d]) begin
      chk({p, ".out_valid"}, 64'(ov), 64'(m_valid[d]));
      chk({p, ".out_data"},  64'(od), 64'(m_data[d]));
      chk({p, ".out_chan"},  64'(oc), 64'(m_chan[d]));
    end
    load = !m_valid[d] || ordy_i;
    g = -1;
    if (!rst) begin
      if (d == 0) begin
        if (int'(s) < C && v[s]) g = int'(s);
      end else begin
        for (int k = 0; k < C; k++) begin
          c = (m_ptr[d] + k) % C;
          if (g < 0 && v[c]) g = c;
        end
      end
    end
    er = '0;
    if (load && g >= 0) er[g] = 1'b1;
    chk({p, ".in_ready"}, 64'(rdy), 64'(er));
    if (rst) begin
      m_valid[d] = 1'b0;
      m_data[d]  = '0;
      m_chan[d]  = '0;
      m_ptr[d]   = 0;
      armed[d]   = 1'b1;
    end else if (load) begin
      if (g >= 0) begin
        m_valid[d] = 1'b1;
        m_data[d]  = data[g*W +: W];
        m_chan[d]  = SW'(g);
        if (d == 1) m_ptr[d] = (g + 1) % C;
      end else begin
        m_valid[d] = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    model_step(0, iv[0], id[0], sel[0], ordy[0], if0.in_ready, if0.out_valid, if0.out_data, if0.out_chan);
    model_step(1, iv[1], id[1], sel[1], ordy[1], if1.in_ready, if1.out_valid, if1.out_data, if1.out_chan);
  end

  int           exp_rr [5] = '{2, 3, 1, 3, 1};
  logic [C-1:0] acc    [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      iv[d]   = '1;
      sel[d]  = 2'd2;
      ordy[d] = 1'b1;
      for (int i = 0; i < C; i++) id[d][i*W +: W] = 32'hA0 + 32'(i);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset.ready0", 64'(if0.in_ready), 64'h0);
    chk("reset.ready1", 64'(if1.in_ready), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle.valid0", 64'(if0.out_valid), 64'h0);
    chk("idle.data0",  64'(if0.out_data),  64'h0);
    chk("idle.valid1", 64'(if1.out_valid), 64'h0);
    chk("idle.ready0", 64'(if0.in_ready),  64'b0100);
    chk("idle.ready1", 64'(if1.in_ready),  64'b0001);

    // Select 2 then 3 on the MODE 0 mux; fair rotation on the MODE 1 mux.
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); #1;
      if (n == 3) sel[0] = 2'd3;
      @(negedge clk);
      chk("sel.stream_data",  64'(if0.out_data),  (n <= 3) ? 64'hA2 : 64'hA3);
      chk("sel.stream_valid", 64'(if0.out_valid), 64'h1);
      chk("rr.rotate_chan",   64'(if1.out_chan),  64'((n - 1) % 4));
    end

    @(posedge clk); #1;
    iv[1] = 4'b1010;
    for (int m = 0; m < 5; m++) begin
      @(negedge clk);
      chk("rr.sparse_chan", 64'(if1.out_chan), 64'(exp_rr[m]));
      @(posedge clk); #1;
    end

    // Backpressure with 0x1234 held, then drain/fill and bubble.
    iv[0] = 4'b0000;
    @(posedge clk); #1;
    id[0][2*W +: W] = 32'h1234;
    sel[0] = 2'd2;
    iv[0]  = 4'b0100;
    @(negedge clk);
    chk("bp.accept_ready", 64'(if0.in_ready), 64'b0100);
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    id[0][2*W +: W] = 32'h55;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp.stall_ready", 64'(if0.in_ready),  64'h0);
      chk("bp.stall_data",  64'(if0.out_data),  64'h1234);
      chk("bp.stall_valid", 64'(if0.out_valid), 64'h1);
      @(posedge clk); #1;
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("bp.release_ready", 64'(if0.in_ready), 64'b0100);
    @(posedge clk); #1;
    @(negedge clk);
    chk("fill.data",  64'(if0.out_data),  64'h55);
    chk("fill.valid", 64'(if0.out_valid), 64'h1);
    @(posedge clk); #1;
    iv[0] = 4'b0000;
    @(negedge clk);
    chk("fill.b2b_valid", 64'(if0.out_valid), 64'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bubble.valid", 64'(if0.out_valid), 64'h0);
    chk("bubble.data",  64'(if0.out_data),  64'h55);

    // Reset while the round-robin pointer sits at 3 with a beat held.
    @(posedge clk); #1;
    iv[1] = 4'b0100;
    @(negedge clk);
    chk("midrst.pre_ready", 64'(if1.in_ready), 64'b0100);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst.held_valid", 64'(if1.out_valid), 64'h1);
    chk("midrst.held_chan",  64'(if1.out_chan),  64'h2);
    chk("midrst.rst_ready",  64'(if1.in_ready),  64'h0);
    @(posedge clk); #1;
    rst   = 1'b0;
    iv[1] = 4'b1111;
    @(negedge clk);
    chk("midrst.valid", 64'(if1.out_valid), 64'h0);
    chk("midrst.ready", 64'(if1.in_ready),  64'b0001);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst.first_chan", 64'(if1.out_chan), 64'h0);

    // Random traffic obeying the producer hold rule.
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      acc[0] = iv[0] & if0.in_ready;
      acc[1] = iv[1] & if1.in_ready;
      @(posedge clk); #1;
      rst = ($urandom_range(0, 199) == 0);
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < C; i++) begin
          if (acc[d][i] || !iv[d][i]) begin
            iv[d][i] = ($urandom_range(0, 9) < 6);
            id[d][i*W +: W] = $urandom;
          end else if ($urandom_range(0, 9) == 0) begin
            iv[d][i] = 1'b0;
          end
        end
        sel[d]  = SW'($urandom);
        ordy[d] = ($urandom_range(0, 9) < 7);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
